// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the device, ACK sample.
// Open-drain style: *_oe=1 pulls the shared line low, 0 releases it.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2d_in,
  input  logic       ps2c_in,
  output logic       ps2d_oe,
  output logic       ps2c_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, WAITREL} state_t;

  state_t                state_q, state_d;
  logic [1:0]            c_sync_q, c_sync_d;
  logic [1:0]            d_sync_q, d_sync_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fc_q, fc_d;
  logic [8:0]            b_q, b_d;
  logic [3:0]            n_q, n_d;
  logic [IW-1:0]         inh_q, inh_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  ack_n_q, ack_n_d;
  logic                  ps2c_oe_q, ps2c_oe_d;
  logic                  ps2d_oe_q, ps2d_oe_d;
  logic                  tx_idle_q, tx_idle_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  fall;
  logic                  timeout_hit;

  always_comb begin
    c_sync_d = {c_sync_q[0], ps2c_in};
    d_sync_d = {d_sync_q[0], ps2d_in};
    filt_d   = {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
    // Filtered clock only moves on a unanimous window, so short glitches hold the old level.
    if (&filt_q)       fc_d = 1'b1;
    else if (~|filt_q) fc_d = 1'b0;
    else               fc_d = fc_q;
    fall = fc_q & ~fc_d;

    state_d   = state_q;
    b_d       = b_q;
    n_d       = n_q;
    inh_d     = inh_q;
    tmo_d     = tmo_q;
    ack_n_d   = ack_n_q;
    ps2c_oe_d = ps2c_oe_q;
    ps2d_oe_d = ps2d_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    timeout_hit = (state_q == START || state_q == DATA || state_q == STOP || state_q == WAITREL)
                  && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    case (state_q)
      IDLE: begin
        if (wr_ps2) begin
          b_d       = {~^din, din};
          inh_d     = '0;
          ps2c_oe_d = 1'b1;
          state_d   = RTS;
        end
      end
      RTS: begin
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
          ps2c_oe_d = 1'b0;
          ps2d_oe_d = 1'b1;
          tmo_d     = '0;
          state_d   = START;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      START: begin
        tmo_d = tmo_q + 1'b1;
        if (fall) begin
          n_d       = 4'd8;
          ps2d_oe_d = ~b_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        tmo_d = tmo_q + 1'b1;
        // Each device clock fall presents the next bit; after parity the line is released as stop.
        if (fall) begin
          if (n_q == 4'd0) begin
            ps2d_oe_d = 1'b0;
            state_d   = STOP;
          end else begin
            b_d       = {1'b0, b_q[8:1]};
            n_d       = n_q - 1'b1;
            ps2d_oe_d = ~b_q[1];
          end
        end
      end
      STOP: begin
        tmo_d = tmo_q + 1'b1;
        if (fall) begin
          ack_n_d = d_sync_q[1];
          state_d = WAITREL;
        end
      end
      WAITREL: begin
        tmo_d = tmo_q + 1'b1;
        if (fc_q && d_sync_q[1]) begin
          done_d  = 1'b1;
          err_d   = ack_n_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      ps2c_oe_d = 1'b0;
      ps2d_oe_d = 1'b0;
      done_d    = 1'b1;
      err_d     = 1'b1;
      state_d   = IDLE;
    end

    tx_idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      c_sync_q  <= '0;
      d_sync_q  <= '0;
      filt_q    <= '0;
      fc_q      <= 1'b0;
      b_q       <= '0;
      n_q       <= '0;
      inh_q     <= '0;
      tmo_q     <= '0;
      ack_n_q   <= 1'b0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      tx_idle_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_sync_q  <= c_sync_d;
      d_sync_q  <= d_sync_d;
      filt_q    <= filt_d;
      fc_q      <= fc_d;
      b_q       <= b_d;
      n_q       <= n_d;
      inh_q     <= inh_d;
      tmo_q     <= tmo_d;
      ack_n_q   <= ack_n_d;
      ps2c_oe_q <= ps2c_oe_d;
      ps2d_oe_q <= ps2d_oe_d;
      tx_idle_q <= tx_idle_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2c_oe      = ps2c_oe_q;
  assign ps2d_oe      = ps2d_oe_q;
  assign tx_idle      = tx_idle_q;
  assign tx_done_tick = done_q;
  assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device drives the clock and reads the frame
// off an open-drain bus model; expected bits, parity and timings are hand-computed constants.
module tb_ps2_host_tx;

  localparam int INHIBIT = 100;
  localparam int TIMEOUT = 5000;
  localparam int HALF    = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2d_oe, ps2c_oe, tx_idle, tx_done_tick, tx_err;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_bus, ps2d_bus;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  assign ps2c_bus = dev_c & ~ps2c_oe;
  assign ps2d_bus = dev_d & ~ps2d_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT), .FILTER_LEN(4)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2d_in(ps2d_bus), .ps2c_in(ps2c_bus),
    .ps2d_oe(ps2d_oe), .ps2c_oe(ps2c_oe), .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick), .tx_err(tx_err)
  );

  always @(negedge clk) if (tx_done_tick === 1'b1) done_cnt++;

  // Device side: wait for the start condition, clock 11 bits, read each bit on the rising edge.
  task automatic device_frame(input logic ack_val, input bit glitch,
                              output logic [9:0] bits, output bit ok);
    int t = 0;
    ok = 1'b1;
    bits = '0;
    while (!(ps2c_bus === 1'b1 && ps2d_bus === 1'b0) && t < 2000) begin
      @(negedge clk); t++;
    end
    if (t >= 2000) begin ok = 1'b0; return; end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b1;
      if (i == 10) begin
        dev_d = 1'b1;
        return;
      end
      bits[i] = ps2d_bus;
      if (i == 9) begin
        repeat (HALF / 2) @(negedge clk);
        dev_d = ack_val;
        repeat (HALF / 2) @(negedge clk);
      end else if (glitch && i == 3) begin
        repeat (10) @(negedge clk);
        dev_c = 1'b0;
        repeat (2) @(negedge clk);
        dev_c = 1'b1;
        repeat (HALF - 12) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic pulse_wr(input logic [7:0] data);
    @(negedge clk);
    din = data;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  task automatic count_rts(input string name);
    int t = 0;
    while (ps2c_oe === 1'b1 && t < 1000) begin
      t++; @(negedge clk);
    end
    checks++;
    if (t !== INHIBIT) begin
      errors++;
      $display("[TB] FAIL %s rts_cycles: got %0d expected %0d", name, t, INHIBIT);
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic ack_val, input bit glitch,
                           input bit poke, input logic [9:0] exp_bits, input logic exp_err,
                           input string name);
    logic [9:0] bits;
    bit ok;
    int t = 0;
    int cnt_before;
    cnt_before = done_cnt;
    pulse_wr(data);
    count_rts(name);
    fork
      device_frame(ack_val, glitch, bits, ok);
      begin
        if (poke) begin
          repeat (300) @(negedge clk);
          din = 8'hAA;
          wr_ps2 = 1'b1;
          @(negedge clk);
          wr_ps2 = 1'b0;
        end
      end
    join
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s start_cond: got 0 expected 1", name);
    end
    checks++;
    if (bits !== exp_bits) begin
      errors++;
      $display("[TB] FAIL %s frame_bits: got %h expected %h", name, bits, exp_bits);
    end
    while (tx_done_tick !== 1'b1 && t < 500) begin
      @(negedge clk); t++;
    end
    checks++;
    if (tx_done_tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done_tick: got %b expected 1", name, tx_done_tick);
    end
    checks++;
    if (tx_err !== exp_err) begin
      errors++;
      $display("[TB] FAIL %s tx_err: got %b expected %b", name, tx_err, exp_err);
    end
    checks++;
    if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL %s lines_released: got %b expected 00", name, {ps2c_oe, ps2d_oe});
    end
    repeat (300) @(negedge clk);
    checks++;
    if (done_cnt !== cnt_before + 1 || tx_idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s single_done: got ticks=%0d idle=%b expected ticks=1 idle=1",
               name, done_cnt - cnt_before, tx_idle);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wr_ps2 = 1'b1;
    din = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2c_oe, ps2d_oe, tx_idle, tx_done_tick} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0010",
               {ps2c_oe, ps2d_oe, tx_idle, tx_done_tick});
    end
    reset = 1'b0;
    wr_ps2 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_idle !== 1'b1 || ps2c_oe !== 1'b0 || done_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL reset_wr_ignored: got idle=%b c_oe=%b ticks=%0d expected 1 0 0",
               tx_idle, ps2c_oe, done_cnt);
    end
  endtask

  // Expected frames are {stop, odd parity, data}; parity is 1 when the data has an even count of ones.
  task automatic test_basic;
    send_byte(8'hED, 1'b0, 1'b0, 1'b0, 10'h3ED, 1'b0, "byte_ED");
  endtask

  task automatic test_parity;
    send_byte(8'h00, 1'b0, 1'b0, 1'b0, 10'h300, 1'b0, "byte_00");
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0, 10'h3FF, 1'b0, "byte_FF");
    send_byte(8'h01, 1'b0, 1'b0, 1'b0, 10'h201, 1'b0, "byte_01");
  endtask

  task automatic test_nack;
    send_byte(8'hF0, 1'b1, 1'b0, 1'b0, 10'h3F0, 1'b1, "nack_F0");
    send_byte(8'h5A, 1'b0, 1'b0, 1'b0, 10'h35A, 1'b0, "after_nack");
  endtask

  task automatic test_timeout;
    int t = 0;
    pulse_wr(8'h12);
    count_rts("timeout");
    while (tx_done_tick !== 1'b1 && t < TIMEOUT + 1000) begin
      @(negedge clk); t++;
    end
    checks++;
    if (t !== TIMEOUT) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: got %0d expected %0d", t, TIMEOUT);
    end
    checks++;
    if ({tx_err, ps2c_oe, ps2d_oe} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL timeout_outputs: got %b expected 100", {tx_err, ps2c_oe, ps2d_oe});
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    send_byte(8'h01, 1'b0, 1'b0, 1'b1, 10'h201, 1'b0, "second_wr_ignored");
  endtask

  task automatic test_glitch;
    send_byte(8'h5A, 1'b0, 1'b1, 1'b0, 10'h35A, 1'b0, "clock_glitch");
  endtask

  task automatic test_reset_mid_frame;
    int t = 0;
    int cnt_before;
    cnt_before = done_cnt;
    pulse_wr(8'h00);
    count_rts("mid_reset");
    while (!(ps2c_bus === 1'b1 && ps2d_bus === 1'b0) && t < 2000) begin
      @(negedge clk); t++;
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 3) begin
        dev_c = 1'b1;
        repeat (HALF) @(negedge clk);
      end
    end
    checks++;
    if (ps2d_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_bit3_driven: got %b expected 1", ps2d_oe);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ps2c_oe, ps2d_oe, tx_idle, tx_done_tick} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got %b expected 0010",
               {ps2c_oe, ps2d_oe, tx_idle, tx_done_tick});
    end
    reset = 1'b0;
    dev_c = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if (done_cnt !== cnt_before || tx_idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_no_tick: got ticks=%0d idle=%b expected 0 1",
               done_cnt - cnt_before, tx_idle);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_glitch();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
